// File: rtl/axi_burst_master.sv
// AXI4 burst initiator: issues one INCR write or read-check burst per command using an address-seeded pattern.
// Optional macro AXI_BURST_MASTER_THROTTLE_EN gates wvalid/rready to alternate cycles.
module axi_burst_master #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                      i_controller_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [AXI_ID_WIDTH-1:0]   i_cmd_id,
  input  logic [7:0]                i_cmd_len,
  output logic                      o_done,
  output logic                      o_error,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                      m_axi_wlast,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                      m_axi_rlast,
  input  logic [1:0]                m_axi_rresp
);

  localparam int WORDS = AXI_DATA_WIDTH / 32;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_FIN} state_t;

  state_t                    state_reg, state_next;
  logic [AXI_ADDR_WIDTH-1:0] addr_reg;
  logic [AXI_ID_WIDTH-1:0]   id_reg;
  logic [7:0]                len_reg;
  logic [7:0]                beat_reg, beat_next;
  logic                      error_reg, error_next;
  logic                      done_reg, done_next;
  logic                      cmd_ready_reg;
  logic                      cmd_accept;
  logic                      last_beat;
  logic                      w_gate, r_gate;
  logic [31:0]               seed;
  logic [31:0]               pattern_word;
  logic [AXI_DATA_WIDTH-1:0] pattern_beat;

  generate
    if (AXI_ADDR_WIDTH >= 32) begin : g_seed_wide
      assign seed = addr_reg[31:0];
    end else begin : g_seed_narrow
      assign seed = {{(32-AXI_ADDR_WIDTH){1'b0}}, addr_reg};
    end
  endgenerate

  assign pattern_word = seed + {24'd0, beat_reg};

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_pattern
      assign pattern_beat[gi*32 +: 32] = pattern_word;
    end
  endgenerate

`ifdef AXI_BURST_MASTER_THROTTLE_EN
  logic toggle_reg, wstall_reg;
  // A stalled beat keeps wvalid up regardless of the toggle phase.
  assign w_gate = toggle_reg | wstall_reg;
  assign r_gate = toggle_reg;
  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      toggle_reg <= 1'b0;
      wstall_reg <= 1'b0;
    end else begin
      toggle_reg <= ~toggle_reg;
      wstall_reg <= m_axi_wvalid & ~m_axi_wready;
    end
  end
`else
  assign w_gate = 1'b1;
  assign r_gate = 1'b1;
`endif

  assign cmd_accept   = (state_reg == S_IDLE) & cmd_ready_reg & i_cmd_valid;
  assign last_beat    = (beat_reg == len_reg);
  assign o_cmd_ready  = cmd_ready_reg;
  assign o_done       = done_reg;
  assign o_error      = error_reg;
  assign m_axi_awid   = id_reg;
  assign m_axi_awaddr = addr_reg;
  assign m_axi_awlen  = len_reg;
  assign m_axi_arid   = id_reg;
  assign m_axi_araddr = addr_reg;
  assign m_axi_arlen  = len_reg;
  assign m_axi_wdata  = pattern_beat;

  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    error_next    = error_reg;
    done_next     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cmd_accept) begin
          beat_next  = 8'd0;
          state_next = i_cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_next = S_W;
      end
      S_W: begin
        m_axi_wvalid = w_gate;
        m_axi_wlast  = w_gate & last_beat;
        if (w_gate && m_axi_wready) begin
          beat_next = beat_reg + 8'd1;
          if (last_beat) state_next = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bid != id_reg || m_axi_bresp != 2'b00) error_next = 1'b1;
          done_next  = 1'b1;
          state_next = S_FIN;
        end
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_next = S_R;
      end
      S_R: begin
        m_axi_rready = r_gate;
        if (r_gate && m_axi_rvalid) begin
          if (m_axi_rdata != pattern_beat || m_axi_rid != id_reg ||
              m_axi_rresp != 2'b00 || m_axi_rlast != last_beat)
            error_next = 1'b1;
          beat_next = beat_reg + 8'd1;
          // An early rlast also terminates the burst.
          if (last_beat || m_axi_rlast) begin
            done_next  = 1'b1;
            state_next = S_FIN;
          end
        end
      end
      S_FIN: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      id_reg        <= '0;
      len_reg       <= '0;
      beat_reg      <= '0;
      error_reg     <= 1'b0;
      done_reg      <= 1'b0;
      cmd_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      error_reg     <= error_next;
      done_reg      <= done_next;
      cmd_ready_reg <= (state_next == S_IDLE);
      if (cmd_accept) begin
        addr_reg <= i_cmd_addr;
        id_reg   <= i_cmd_id;
        len_reg  <= i_cmd_len;
      end
    end
  end

endmodule
